// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Synchronizes a raw push-button input and debounces it into a
//                clean level plus one-cycle rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================

module button_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Only the first synchronizer flop ever samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (sync_s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end

            // Any disagreeing sample throws away all accumulated credit.
            ST_WAIT_HIGH: begin
                if (!sync_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_HIGH: begin
                if (!sync_s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_LOW: begin
                if (sync_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Self-checking bench for button_debounce (STABLE_CYCLES 4 and 1)
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_button_debounce;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_in  = 1'b0;
    logic btn_in1 = 1'b0;
    logic lvl, rise, fall;
    logic lvl1, rise1, fall1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(lvl), .btn_rise(rise), .btn_fall(fall)
    );

    button_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in1),
        .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1)
    );

    // Reference: a level flips once the synchronized stream has shown
    // STABLE+1 consecutive samples that disagree with it.
    bit [1:0] m_pipe  [2];
    int       m_run   [2];
    bit       m_level [2];
    bit       m_rise  [2];
    bit       m_fall  [2];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pipe[i] = 2'b00; m_run[i] = 0;
            m_level[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        end
    endtask

    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            bit sv;
            bit din;
            int need;
            need = (i == 0) ? 5 : 2;
            sv   = m_pipe[i][1];
            din  = (i == 0) ? btn_in : btn_in1;
            m_pipe[i] = {m_pipe[i][0], din};
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (sv != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == need) begin
                    m_level[i] = sv;
                    m_rise[i]  = sv;
                    m_fall[i]  = !sv;
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_reset();
        else        m_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        for (int c = 0; c < 6; c++) begin
            btn_in  = 1'($urandom);
            btn_in1 = 1'($urandom);
            tick();
            n_cmp++;
            if ({lvl, rise, fall, lvl1, rise1, fall1} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=000000", c,
                         {lvl, rise, fall, lvl1, rise1, fall1});
            end
        end
        btn_in  = 1'b0;
        btn_in1 = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if ({lvl, rise, fall} !== {m_level[0], m_rise[0], m_fall[0]}) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", c,
                         {lvl, rise, fall}, {m_level[0], m_rise[0], m_fall[0]});
            end
        end
    endtask

    task automatic test_clean_press();
        tick();
        btn_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_cmp++;
            if ({lvl, rise, fall} !== {1'(e >= 7), 1'(e == 7), 1'b0}) begin
                n_bad++;
                $display("FAIL press_timing edge=%0d got=%b exp=%b", e,
                         {lvl, rise, fall}, {1'(e >= 7), 1'(e == 7), 1'b0});
            end
        end
        btn_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++;
            if ({lvl, rise, fall} !== {m_level[0], m_rise[0], m_fall[0]}) begin
                n_bad++;
                $display("FAIL press_release cyc=%0d got=%b exp=%b", c,
                         {lvl, rise, fall}, {m_level[0], m_rise[0], m_fall[0]});
            end
        end
    endtask

    task automatic test_glitch();
        int n_r;
        int n_f;
        tick();
        btn_in = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 4) btn_in = 1'b0;
            n_cmp++;
            if ({lvl, rise, fall} !== 3'b000) begin
                n_bad++;
                $display("FAIL glitch4 edge=%0d got=%b exp=000", e, {lvl, rise, fall});
            end
        end
        n_r = 0;
        n_f = 0;
        tick();
        btn_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 5) btn_in = 1'b0;
            n_r += int'(rise);
            n_f += int'(fall);
            n_cmp++;
            if ({lvl, rise, fall} !== {1'(e >= 7 && e < 12), 1'(e == 7), 1'(e == 12)}) begin
                n_bad++;
                $display("FAIL glitch5 edge=%0d got=%b exp=%b", e, {lvl, rise, fall},
                         {1'(e >= 7 && e < 12), 1'(e == 7), 1'(e == 12)});
            end
        end
        n_cmp++;
        if (n_r != 1 || n_f != 1) begin
            n_bad++;
            $display("FAIL glitch5_count rises=%0d falls=%0d exp=1/1", n_r, n_f);
        end
    endtask

    task automatic test_bounce();
        int n_r;
        int n_f;
        tick();
        btn_in = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        n_cmp++;
        if (lvl !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_pressed got=%b exp=1", lvl);
        end
        n_r = 0;
        n_f = 0;
        for (int i = 0; i < 20; i++) begin
            btn_in = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            n_r += int'(rise);
            n_f += int'(fall);
            n_cmp++;
            if ({lvl, rise, fall} !== {m_level[0], m_rise[0], m_fall[0]}) begin
                n_bad++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i,
                         {lvl, rise, fall}, {m_level[0], m_rise[0], m_fall[0]});
            end
        end
        btn_in = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_r += int'(rise);
            n_f += int'(fall);
            n_cmp++;
            if (fall !== 1'(e == 7)) begin
                n_bad++;
                $display("FAIL bounce_fall edge=%0d got=%b exp=%b", e, fall, 1'(e == 7));
            end
        end
        n_cmp++;
        if (n_r != 0 || n_f != 1) begin
            n_bad++;
            $display("FAIL bounce_count rises=%0d falls=%0d exp=0/1", n_r, n_f);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        btn_in = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        rst_n = 1'b0;
        m_reset();
        #1;
        n_cmp++;
        if ({lvl, rise, fall} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_wait got=%b exp=000", {lvl, rise, fall});
        end
        for (int c = 0; c < 3; c++) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_cmp++;
            if ({lvl, rise} !== {1'(e >= 7), 1'(e == 7)}) begin
                n_bad++;
                $display("FAIL reset_repress edge=%0d got=%b exp=%b", e,
                         {lvl, rise}, {1'(e >= 7), 1'(e == 7)});
            end
        end
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_cmp++;
        if ({lvl, rise, fall} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_cut_pulse got=%b exp=000", {lvl, rise, fall});
        end
        btn_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if ({lvl, rise, fall} !== {m_level[0], m_rise[0], m_fall[0]}) begin
                n_bad++;
                $display("FAIL reset_after cyc=%0d got=%b exp=%b", c,
                         {lvl, rise, fall}, {m_level[0], m_rise[0], m_fall[0]});
            end
        end
    endtask

    task automatic test_stable1();
        tick();
        btn_in1 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) btn_in1 = 1'b0;
            n_cmp++;
            if ({lvl1, rise1, fall1} !== 3'b000) begin
                n_bad++;
                $display("FAIL s1_reject edge=%0d got=%b exp=000", e, {lvl1, rise1, fall1});
            end
        end
        tick();
        btn_in1 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 2) btn_in1 = 1'b0;
            n_cmp++;
            if ({lvl1, rise1, fall1} !== {1'(e == 4 || e == 5), 1'(e == 4), 1'(e == 6)}) begin
                n_bad++;
                $display("FAIL s1_accept edge=%0d got=%b exp=%b", e, {lvl1, rise1, fall1},
                         {1'(e == 4 || e == 5), 1'(e == 4), 1'(e == 6)});
            end
        end
    endtask

    task automatic test_random_stream();
        int left0;
        int left1;
        left0 = 0;
        left1 = 0;
        for (int c = 0; c < 800; c++) begin
            if (left0 == 0) begin
                btn_in = 1'($urandom);
                left0  = int'($urandom_range(1, 8));
            end
            if (left1 == 0) begin
                btn_in1 = 1'($urandom);
                left1   = int'($urandom_range(1, 4));
            end
            left0--;
            left1--;
            tick();
            n_cmp++;
            if ({lvl, rise, fall, lvl1, rise1, fall1} !==
                {m_level[0], m_rise[0], m_fall[0], m_level[1], m_rise[1], m_fall[1]}) begin
                n_bad++;
                $display("FAIL random_stream cyc=%0d got=%b exp=%b", c,
                         {lvl, rise, fall, lvl1, rise1, fall1},
                         {m_level[0], m_rise[0], m_fall[0], m_level[1], m_rise[1], m_fall[1]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_stable1();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
